// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder tile.
//   phase_t      : filtered {A,B} phase, encoded as the literal {A,B} value
//   *_BIT        : ui_in / uio_out bit positions
//   UIO_OE_VAL   : constant bidirectional output-enable pattern
//   phase_fwd/rev: neighbour of a phase in the forward / reverse direction
package qdec_pkg;

    typedef enum logic [1:0] {
        P00 = 2'b00,
        P01 = 2'b01,
        P11 = 2'b11,
        P10 = 2'b10
    } phase_t;

    localparam int A_BIT      = 0;
    localparam int B_BIT      = 1;
    localparam int IDX_BIT    = 2;
    localparam int DIRINV_BIT = 3;
    localparam int CLR_BIT    = 4;

    localparam int DIR_BIT  = 0;
    localparam int STEP_BIT = 1;
    localparam int ERR_BIT  = 2;
    localparam int WRAP_BIT = 3;

    localparam logic [7:0] UIO_OE_VAL = 8'h0F;

    function automatic phase_t phase_fwd(input phase_t p);
        case (p)
            P00:     return P01;
            P01:     return P11;
            P11:     return P10;
            default: return P00;
        endcase
    endfunction

    function automatic phase_t phase_rev(input phase_t p);
        case (p)
            P00:     return P10;
            P10:     return P11;
            P11:     return P01;
            default: return P00;
        endcase
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// Single-bit input conditioner: SYNC_STAGES-flop synchroniser followed by a
// stability filter. The output only moves to a new level once FILTER_LEN
// consecutive synchronised samples all disagree with the current output.
// Ports:
//   clk, rst_n : tile clock, async active-low reset (output resets to 0)
//   din        : raw asynchronous pin
//   dout       : synchronised, filtered level
module qdec_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Down-counter restarts whenever the synced sample agrees with the output,
    // so only an unbroken run of disagreeing samples reaches terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= RELOAD;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (synced == dout) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                dout  <= synced;
                cnt_q <= RELOAD;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/tt_um_quadrature_decoder.sv
// Quadrature decoder Tiny Tapeout tile. Filters the A/B phase pins, decodes
// Gray-code steps into an 8-bit wrapping position count.
// Ports:
//   clk, rst_n : tile clock, async active-low reset
//   ena        : tile enable; low freezes count/dir/err, step/wrap forced 0
//   ui_in      : [0]=A [1]=B [2]=index [3]=dir_inv [4]=clear
//   uo_out     : position count
//   uio_in     : unused
//   uio_out    : [0]=dir [1]=step [2]=err [3]=wrap, [7:4]=0
//   uio_oe     : constant 8'h0F
// Build option: define QDEC_INDEX_EN to add the index input; a filtered index
// rising edge while filtered {A,B}=11 zeroes the count.
//
// Phase FSM (state = last filtered {A,B}):
//   state | meaning
//   P00   | A=0 B=0
//   P01   | A=0 B=1 (one step forward of P00)
//   P11   | A=1 B=1
//   P10   | A=1 B=0 (one step reverse of P00)
//   init_q qualifies the first cycle after reset: phase loads without counting.
module tt_um_quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       a_f, b_f;
    phase_t     ab_f, phase_q, phase_d;
    logic       init_q;
    logic       mv, fwd, illegal, up, idx_hit, clr;
    logic [7:0] count_q;
    logic       dir_q, step_q, err_q, wrap_q;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk (clk), .rst_n (rst_n), .din (ui_in[A_BIT]), .dout (a_f)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk (clk), .rst_n (rst_n), .din (ui_in[B_BIT]), .dout (b_f)
    );

    assign ab_f = phase_t'({a_f, b_f});
    // dir_inv and clear are treated as synchronous levels, no conditioning.
    assign clr  = ui_in[CLR_BIT];
    assign up   = fwd ^ ui_in[DIRINV_BIT];

`ifdef QDEC_INDEX_EN
    logic idx_f, idx_q;
    logic unused;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_idx (
        .clk (clk), .rst_n (rst_n), .din (ui_in[IDX_BIT]), .dout (idx_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= 1'b0;
        else        idx_q <= idx_f;
    end

    assign idx_hit = idx_f & ~idx_q & (ab_f == P11);
    assign unused  = &{1'b0, uio_in, ui_in[7:5]};
`else
    logic unused;
    assign idx_hit = 1'b0;
    assign unused  = &{1'b0, uio_in, ui_in[7:5], ui_in[IDX_BIT]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= P00;
            init_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            init_q  <= 1'b0;
        end
    end

    // Phase always follows the filtered pins, even with ena low, so that
    // edges missed while disabled never produce a catch-up step.
    always_comb begin
        phase_d = ab_f;
        mv      = 1'b0;
        fwd     = 1'b0;
        illegal = 1'b0;
        if (!init_q && (ab_f != phase_q)) begin
            if (ab_f == phase_fwd(phase_q)) begin
                mv  = 1'b1;
                fwd = 1'b1;
            end else if (ab_f == phase_rev(phase_q)) begin
                mv  = 1'b1;
            end else begin
                illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (ena) begin
                if (clr) begin
                    count_q <= 8'd0;
                    err_q   <= 1'b0;
                end else if (idx_hit) begin
                    count_q <= 8'd0;
                end else if (mv) begin
                    count_q <= up ? count_q + 8'd1 : count_q - 8'd1;
                    step_q  <= 1'b1;
                    dir_q   <= up;
                    wrap_q  <= up ? (count_q == 8'hFF) : (count_q == 8'h00);
                end
                if (!clr && illegal) err_q <= 1'b1;
            end
        end
    end

    assign uo_out = count_q;
    assign uio_oe = UIO_OE_VAL;

    always_comb begin
        uio_out           = 8'h00;
        uio_out[DIR_BIT]  = dir_q;
        uio_out[STEP_BIT] = step_q;
        uio_out[ERR_BIT]  = err_q;
        uio_out[WRAP_BIT] = wrap_q;
    end

endmodule

// File: tb/tb_tt_um_quadrature_decoder.sv
module tb_tt_um_quadrature_decoder;

    localparam int SS = 2;
    localparam int FL = 3;
    localparam int HN = SS + FL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_quadrature_decoder #(.SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        int dirn;
        int hold;
        int dinv;
        int exp_cnt;
        int exp_dir;
        int exp_wraps;
    } vec_t;

    vec_t tbl[19];

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;
    int pos = 0;

    // reference model: pin history window, filtered levels, position arithmetic
    int ha[HN], hb[HN], hi[HN];
    int fa, fb, fi, fi_prev;
    int m_phase, m_init, m_cnt, m_dir, m_step, m_wrap, m_err;

    function automatic int gi(input int a, input int b);
        if (a == 0 && b == 0) return 0;
        if (a == 0 && b == 1) return 1;
        if (a == 1 && b == 1) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < HN; k++) begin
            ha[k] = 0; hb[k] = 0; hi[k] = 0;
        end
        fa = 0; fb = 0; fi = 0; fi_prev = 0;
        m_phase = 0; m_init = 1; m_cnt = 0; m_dir = 0;
        m_step = 0; m_wrap = 0; m_err = 0;
    endtask

    function automatic int window(input int h[HN], input int cur);
        int v;
        v = h[SS-1];
        for (int k = SS; k <= SS + FL - 2; k++)
            if (h[k] != v) return cur;
        return v;
    endfunction

    task automatic model_step();
        int d, up, idx_hit, ph_new, clr, dinv;
        clr  = int'(ui_in[4]);
        dinv = int'(ui_in[3]);
        ph_new = gi(fa, fb);
        d = m_init ? 0 : (ph_new - m_phase + 4) % 4;
        m_phase = ph_new;
        m_init  = 0;
        idx_hit = 0;
`ifdef QDEC_INDEX_EN
        idx_hit = (fi == 1 && fi_prev == 0 && fa == 1 && fb == 1) ? 1 : 0;
`endif
        m_step = 0;
        m_wrap = 0;
        if (ena) begin
            if (clr) begin
                m_cnt = 0;
                m_err = 0;
            end else if (idx_hit) begin
                m_cnt = 0;
            end else if (d == 1 || d == 3) begin
                up = ((d == 1) ? 1 : 0) ^ dinv;
                if (up) begin
                    m_wrap = (m_cnt == 255) ? 1 : 0;
                    m_cnt  = (m_cnt + 1) % 256;
                end else begin
                    m_wrap = (m_cnt == 0) ? 1 : 0;
                    m_cnt  = (m_cnt + 255) % 256;
                end
                m_step = 1;
                m_dir  = up;
            end
            if (!clr && d == 2) m_err = 1;
        end
        fi_prev = fi;
        fa = window(ha, fa);
        fb = window(hb, fb);
        fi = window(hi, fi);
        for (int k = HN - 1; k > 0; k--) begin
            ha[k] = ha[k-1]; hb[k] = hb[k-1]; hi[k] = hi[k-1];
        end
        ha[0] = int'(ui_in[0]);
        hb[0] = int'(ui_in[1]);
        hi[0] = int'(ui_in[2]);
    endtask

    task automatic tick();
        int exp_st;
        @(posedge clk);
        model_step();
        #1;
        if (cmp_on) begin
            exp_st = m_dir + 2 * m_step + 4 * m_err + 8 * m_wrap;
            chk("rand_count", int'(uo_out), m_cnt);
            chk("rand_status", int'(uio_out), exp_st);
        end
    endtask

    task automatic hold(input int n, output int steps, output int wraps);
        steps = 0;
        wraps = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            steps += int'(uio_out[1]);
            wraps += int'(uio_out[3]);
        end
    endtask

    task automatic set_pos(input int k);
        pos = ((k % 4) + 4) % 4;
        case (pos)
            0: begin ui_in[0] = 1'b0; ui_in[1] = 1'b0; end
            1: begin ui_in[0] = 1'b0; ui_in[1] = 1'b1; end
            2: begin ui_in[0] = 1'b1; ui_in[1] = 1'b1; end
            default: begin ui_in[0] = 1'b1; ui_in[1] = 1'b0; end
        endcase
    endtask

    task automatic do_reset();
        ui_in = 8'h00;
        ena   = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        pos = 0;
        chk("reset_count", int'(uo_out), 0);
        chk("reset_status", int'(uio_out), 0);
        chk("reset_oe", int'(uio_oe), 15);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input int dirn, input int dinv, input int cnt,
                                input int dir, input int wraps);
        vec_t v;
        v.dirn = dirn; v.hold = 10; v.dinv = dinv;
        v.exp_cnt = cnt; v.exp_dir = dir; v.exp_wraps = wraps;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, wr, st2, wr2, exp_cnt, old_g, new_g, d, n;

        for (int i = 0; i < 8; i++) tbl[i] = mk(1, 0, i + 1, 1, 0);
        for (int i = 8; i < 16; i++) tbl[i] = mk(-1, 0, 15 - i, 0, 0);
        tbl[16] = mk(-1, 0, 255, 0, 1);
        tbl[17] = mk(1, 1, 254, 0, 0);
        tbl[18] = mk(1, 1, 253, 0, 0);

        do_reset();

        // forward, reverse through 0->255, dir_inv
        for (int i = 0; i < 19; i++) begin
            ui_in[3] = tbl[i].dinv[0];
            set_pos(pos + tbl[i].dirn);
            hold(tbl[i].hold, st, wr);
            chk($sformatf("tbl%0d_count", i), int'(uo_out), tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_dir", i), int'(uio_out[0]), tbl[i].exp_dir);
            chk($sformatf("tbl%0d_steps", i), st, 1);
            chk($sformatf("tbl%0d_wraps", i), wr, tbl[i].exp_wraps);
            chk($sformatf("tbl%0d_err", i), int'(uio_out[2]), 0);
        end
        ui_in[3] = 1'b0;

        // latency: 6 edges from the first sampling edge
        set_pos(pos + 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("lat_hold%0d", k), int'(uo_out), 253);
        end
        tick();
        chk("lat_count", int'(uo_out), 254);
        chk("lat_step", int'(uio_out[1]), 1);
        hold(4, st, wr);

        // glitch shorter than the filter, then a clean A change
        ui_in[0] = ~ui_in[0];
        hold(2, st, wr);
        ui_in[0] = ~ui_in[0];
        hold(12, st2, wr2);
        chk("glitch_steps", st + st2, 0);
        chk("glitch_count", int'(uo_out), 254);
        old_g = gi(int'(ui_in[0]), int'(ui_in[1]));
        ui_in[0] = ~ui_in[0];
        new_g = gi(int'(ui_in[0]), int'(ui_in[1]));
        pos = new_g;
        d = (new_g - old_g + 4) % 4;
        exp_cnt = (d == 1) ? 255 : 253;
        hold(4, st, wr);
        hold(10, st2, wr2);
        chk("a4_steps", st + st2, 1);
        chk("a4_count", int'(uo_out), exp_cnt);

        // illegal jump: err sticky, count held; clear resets both
        ui_in[1:0] = ~ui_in[1:0];
        pos = gi(int'(ui_in[0]), int'(ui_in[1]));
        hold(10, st, wr);
        chk("jump_count", int'(uo_out), exp_cnt);
        chk("jump_err", int'(uio_out[2]), 1);
        chk("jump_steps", st, 0);
        set_pos(pos + 1);
        hold(10, st, wr);
        exp_cnt = (exp_cnt + 1) % 256;
        chk("sticky_count", int'(uo_out), exp_cnt);
        chk("sticky_err", int'(uio_out[2]), 1);
        ui_in[4] = 1'b1;
        tick();
        ui_in[4] = 1'b0;
        chk("clr_count", int'(uo_out), 0);
        chk("clr_err", int'(uio_out[2]), 0);
        hold(3, st, wr);

        // disabled steps are lost
        ena = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            set_pos(pos + 1);
            hold(10, st, wr);
            n += st;
        end
        chk("ena0_count", int'(uo_out), 0);
        chk("ena0_steps", n, 0);
        ena = 1'b1;
        set_pos(pos + 1);
        hold(10, st, wr);
        chk("ena1_count", int'(uo_out), 1);
        chk("ena1_steps", st, 1);

        // clear coinciding with the edge on which the step lands
        set_pos(pos + 1);
        repeat (5) tick();
        chk("cs_pre", int'(uo_out), 1);
        ui_in[4] = 1'b1;
        tick();
        chk("cs_count", int'(uo_out), 0);
        chk("cs_step", int'(uio_out[1]), 0);
        ui_in[4] = 1'b0;
        hold(8, st, wr);
        chk("cs_after", int'(uo_out), 0);
        chk("cs_after_steps", st, 0);

`ifdef QDEC_INDEX_EN
        for (int k = 0; k < 4; k++)
            if (pos != 1) begin
                set_pos(pos + 1);
                hold(10, st, wr);
            end
        ui_in[4] = 1'b1;
        tick();
        ui_in[4] = 1'b0;
        for (int k = 0; k < 37; k++) begin
            set_pos(pos + 1);
            hold(7, st, wr);
        end
        chk("idx_pre", int'(uo_out), 37);
        ui_in[2] = 1'b1;
        hold(10, st, wr);
        chk("idx11_count", int'(uo_out), 0);
        ui_in[2] = 1'b0;
        hold(10, st, wr);
        set_pos(pos - 1);
        hold(10, st, wr);
        chk("idx01_pre", int'(uo_out), 255);
        ui_in[2] = 1'b1;
        hold(10, st, wr);
        chk("idx01_count", int'(uo_out), 255);
        ui_in[2] = 1'b0;
        hold(10, st, wr);
`else
        ui_in[4] = 1'b1;
        tick();
        ui_in[4] = 1'b0;
        n = (2 - pos + 4) % 4;
        for (int k = 0; k < n; k++) begin
            set_pos(pos + 1);
            hold(10, st, wr);
        end
        ui_in[2] = 1'b1;
        hold(10, st, wr);
        ui_in[2] = 1'b0;
        hold(10, st2, wr2);
        chk("noidx_count", int'(uo_out), n);
`endif

        // asynchronous reset mid-step
        ui_in[4] = 1'b1;
        tick();
        ui_in[4] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_pos(pos + 1);
            hold(10, st, wr);
        end
        chk("mr_pre_count", int'(uo_out), 3);
        chk("mr_pre_dir", int'(uio_out[0]), 1);
        set_pos(pos + 1);
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #2;
        chk("mr_count", int'(uo_out), 0);
        chk("mr_status", int'(uio_out), 0);

        // randomized segments against the reference model
        do_reset();
        cmp_on = 1'b1;
        for (int s = 0; s < 220; s++) begin
            n = $urandom_range(0, 19);
            if (n < 8)       set_pos(pos + 1);
            else if (n < 16) set_pos(pos + 3);
            else if (n < 18) set_pos(pos + 2);
            ena      = ($urandom_range(0, 7) != 0);
            ui_in[3] = ($urandom_range(0, 5) == 0);
            ui_in[2] = $urandom_range(0, 1) != 0;
            ui_in[4] = ($urandom_range(0, 15) == 0);
            tick();
            ui_in[4] = 1'b0;
            repeat ($urandom_range(0, 11)) tick();
        end
        cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
